// File: rtl/pll_cfg_ctrl.sv
// PLL divider reconfiguration sequencer: gates the output clock, swaps dividers,
// blanks, then requalifies a synchronized lock before re-enabling the clock.
//
// state     | meaning
// LOCK_WAIT | clock gated, qualifying lock, timeout running
// RUN       | locked, clock enabled, accepting requests
// GATE      | clock gated ahead of the divider change
// BLANK     | dividers changed, lock ignored while the loop settles
// FAIL      | lock timed out, err_o held, accepting requests
module pll_cfg_ctrl #(
  parameter int REF_DIV_WIDTH = 4,
  parameter int FB_DIV_WIDTH  = 8,
  parameter int RST_REFDIV    = 1,
  parameter int RST_FBDIV     = 8,
  parameter int GATE_CYCLES   = 4,
  parameter int BLANK_CYCLES  = 8,
  parameter int LOCK_STABLE   = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     cfg_valid_i,
  input  logic [REF_DIV_WIDTH-1:0] cfg_refdiv_i,
  input  logic [FB_DIV_WIDTH-1:0]  cfg_fbdiv_i,
  output logic                     cfg_ready_o,
  input  logic                     pll_locked_i,
  output logic [REF_DIV_WIDTH-1:0] refdiv_o,
  output logic [FB_DIV_WIDTH-1:0]  fbdiv_o,
  output logic                     clk_en_o,
  output logic                     done_o,
  output logic                     lost_lock_o,
  output logic                     cfg_err_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    LOCK_WAIT = 3'd0,
    RUN       = 3'd1,
    GATE      = 3'd2,
    BLANK     = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int GB_MAX  = (GATE_CYCLES > BLANK_CYCLES) ? GATE_CYCLES : BLANK_CYCLES;
  localparam int CNT_MAX = (GB_MAX > TIMEOUT) ? GB_MAX : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_SAT    = STB_W'(LOCK_STABLE);
  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(LOCK_STABLE - 1);

  state_e                   state_q, state_d;
  logic [1:0]               sync_q, sync_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [STB_W-1:0]         stb_q, stb_d, stb_inc;
  logic [REF_DIV_WIDTH-1:0] refdiv_q, refdiv_d, req_ref_q, req_ref_d;
  logic [FB_DIV_WIDTH-1:0]  fbdiv_q, fbdiv_d, req_fb_q, req_fb_d;
  logic                     clk_en_q, clk_en_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     lost_q, lost_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     err_q, err_d;
  logic                     lk, accept, req_zero, start;

  assign lk       = sync_q[1];
  assign accept   = cfg_valid_i & ready_q;
  assign req_zero = (cfg_refdiv_i == '0) | (cfg_fbdiv_i == '0);
  assign start    = accept & ~req_zero;
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign stb_inc  = (stb_q == STB_SAT) ? stb_q : stb_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], pll_locked_i};
    cnt_d     = cnt_q;
    stb_d     = stb_q;
    refdiv_d  = refdiv_q;
    fbdiv_d   = fbdiv_q;
    req_ref_d = req_ref_q;
    req_fb_d  = req_fb_q;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    cfg_err_d = 1'b0;
    err_d     = err_q;

    if (accept) begin
      req_ref_d = cfg_refdiv_i;
      req_fb_d  = cfg_fbdiv_i;
      cfg_err_d = req_zero;
    end

    case (state_q)
      LOCK_WAIT: begin
        cnt_d = cnt_inc;
        stb_d = lk ? stb_inc : '0;
        // Lock takes priority over a timeout landing on the same edge.
        if (lk && stb_q == STB_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        lost_d = ~lk;
        if (start) begin
          state_d = GATE;
          cnt_d   = '0;
        end else if (!lk) begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
          stb_d   = '0;
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST) begin
          refdiv_d = req_ref_q;
          fbdiv_d  = req_fb_q;
          state_d  = BLANK;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
          stb_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FAIL: begin
        err_d = 1'b1;
        if (start) begin
          state_d = GATE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = LOCK_WAIT;
        cnt_d   = '0;
        stb_d   = '0;
      end
    endcase

    clk_en_d = (state_d == RUN);
    ready_d  = (state_d == RUN) || (state_d == FAIL);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= LOCK_WAIT;
      sync_q    <= '0;
      cnt_q     <= '0;
      stb_q     <= '0;
      refdiv_q  <= REF_DIV_WIDTH'(RST_REFDIV);
      fbdiv_q   <= FB_DIV_WIDTH'(RST_FBDIV);
      req_ref_q <= REF_DIV_WIDTH'(RST_REFDIV);
      req_fb_q  <= FB_DIV_WIDTH'(RST_FBDIV);
      clk_en_q  <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      lost_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      refdiv_q  <= refdiv_d;
      fbdiv_q   <= fbdiv_d;
      req_ref_q <= req_ref_d;
      req_fb_q  <= req_fb_d;
      clk_en_q  <= clk_en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
      cfg_err_q <= cfg_err_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign refdiv_o    = refdiv_q;
  assign fbdiv_o     = fbdiv_q;
  assign clk_en_o    = clk_en_q;
  assign done_o      = done_q;
  assign lost_lock_o = lost_q;
  assign cfg_err_o   = cfg_err_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Directed bench for pll_cfg_ctrl with default parameters; expected values are
// hand-derived edge counts relative to reset release or request acceptance.
module tb_pll_cfg_ctrl;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       cfg_valid_i;
  logic [3:0] cfg_refdiv_i;
  logic [7:0] cfg_fbdiv_i;
  logic       cfg_ready_o;
  logic       pll_locked_i;
  logic [3:0] refdiv_o;
  logic [7:0] fbdiv_o;
  logic       clk_en_o;
  logic       done_o;
  logic       lost_lock_o;
  logic       cfg_err_o;
  logic       err_o;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk_i = ~clk_i;

  pll_cfg_ctrl dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_refdiv_i (cfg_refdiv_i),
    .cfg_fbdiv_i  (cfg_fbdiv_i),
    .cfg_ready_o  (cfg_ready_o),
    .pll_locked_i (pll_locked_i),
    .refdiv_o     (refdiv_o),
    .fbdiv_o      (fbdiv_o),
    .clk_en_o     (clk_en_o),
    .done_o       (done_o),
    .lost_lock_o  (lost_lock_o),
    .cfg_err_o    (cfg_err_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic [3:0] r, input logic [7:0] f);
    cfg_valid_i  = 1'b1;
    cfg_refdiv_i = r;
    cfg_fbdiv_i  = f;
  endtask

  logic glitch_done, glitch_en;

  initial begin
    arst_ni      = 1'b0;
    cfg_valid_i  = 1'b0;
    cfg_refdiv_i = '0;
    cfg_fbdiv_i  = '0;
    pll_locked_i = 1'b1;
    step(3);
    chk("rst_refdiv", refdiv_o, 1);
    chk("rst_fbdiv", fbdiv_o, 8);
    chk("rst_clk_en", clk_en_o, 0);
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_lost", lost_lock_o, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    chk("rst_err", err_o, 0);

    // Lock held high through reset: RUN exactly 18 edges after release.
    arst_ni = 1'b1;
    step(17);
    chk("lock17_done", done_o, 0);
    chk("lock17_clk_en", clk_en_o, 0);
    step(1);
    chk("lock18_done", done_o, 1);
    chk("lock18_clk_en", clk_en_o, 1);
    chk("lock18_ready", cfg_ready_o, 1);
    step(1);
    chk("lock19_done", done_o, 0);

    // Reconfigure to 2/20.
    request(4'd2, 8'd20);
    step(1);
    cfg_valid_i = 1'b0;
    chk("cfg_e0_clk_en", clk_en_o, 0);
    chk("cfg_e0_ready", cfg_ready_o, 0);
    step(3);
    chk("cfg_e3_fbdiv", fbdiv_o, 8);
    step(1);
    chk("cfg_e4_refdiv", refdiv_o, 2);
    chk("cfg_e4_fbdiv", fbdiv_o, 20);
    step(23);
    chk("cfg_e27_done", done_o, 0);
    step(1);
    chk("cfg_e28_done", done_o, 1);
    chk("cfg_e28_clk_en", clk_en_o, 1);

    // One-cycle lock drop in RUN.
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(1);
    chk("drop2_clk_en", clk_en_o, 1);
    chk("drop2_lost", lost_lock_o, 0);
    step(1);
    chk("drop3_lost", lost_lock_o, 1);
    chk("drop3_clk_en", clk_en_o, 0);
    step(1);
    chk("drop4_lost", lost_lock_o, 0);
    step(14);
    chk("drop18_done", done_o, 0);
    step(1);
    chk("drop19_done", done_o, 1);
    chk("drop19_clk_en", clk_en_o, 1);

    // 5-high/5-low glitch train must never qualify.
    pll_locked_i = 1'b0;
    step(3);
    chk("glitch_lost", lost_lock_o, 1);
    glitch_done = 1'b0;
    glitch_en   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pll_locked_i = ~pll_locked_i;
      for (int j = 0; j < 5; j++) begin
        step(1);
        glitch_done |= done_o;
        glitch_en   |= clk_en_o;
      end
    end
    chk("glitch_done", glitch_done, 0);
    chk("glitch_clk_en", glitch_en, 0);
    pll_locked_i = 1'b1;
    step(17);
    chk("requal17_done", done_o, 0);
    step(1);
    chk("requal18_done", done_o, 1);

    // Zero dividers are rejected without disturbing RUN.
    request(4'd3, 8'd0);
    step(1);
    chk("zfb_cfg_err", cfg_err_o, 1);
    chk("zfb_fbdiv", fbdiv_o, 20);
    chk("zfb_clk_en", clk_en_o, 1);
    chk("zfb_ready", cfg_ready_o, 1);
    request(4'd0, 8'd9);
    step(1);
    chk("zref_cfg_err", cfg_err_o, 1);
    chk("zref_refdiv", refdiv_o, 2);
    cfg_valid_i = 1'b0;
    step(1);
    chk("zero_after_cfg_err", cfg_err_o, 0);
    chk("zero_after_clk_en", clk_en_o, 1);
    chk("zero_after_fbdiv", fbdiv_o, 20);

    // Lock lost and never returns: timeout after 4096 LOCK_WAIT cycles.
    pll_locked_i = 1'b0;
    step(3);
    chk("to_lost", lost_lock_o, 1);
    step(4095);
    chk("to_4095_err", err_o, 0);
    step(1);
    chk("to_4096_err", err_o, 1);
    chk("to_ready", cfg_ready_o, 1);
    chk("to_clk_en", clk_en_o, 0);
    pll_locked_i = 1'b1;
    step(10);
    chk("fail_lk_err", err_o, 1);
    chk("fail_lk_clk_en", clk_en_o, 0);
    request(4'd4, 8'd30);
    step(1);
    cfg_valid_i = 1'b0;
    chk("fail_req_err", err_o, 0);
    chk("fail_req_ready", cfg_ready_o, 0);
    step(4);
    chk("fail_req_refdiv", refdiv_o, 4);
    chk("fail_req_fbdiv", fbdiv_o, 30);
    step(24);
    chk("fail_req_done", done_o, 1);

    // Reset asserted while in GATE.
    request(4'd5, 8'd50);
    step(1);
    cfg_valid_i = 1'b0;
    step(2);
    arst_ni = 1'b0;
    #1;
    chk("gate_rst_refdiv", refdiv_o, 1);
    chk("gate_rst_fbdiv", fbdiv_o, 8);
    chk("gate_rst_ready", cfg_ready_o, 0);
    chk("gate_rst_clk_en", clk_en_o, 0);
    step(2);
    arst_ni = 1'b1;
    step(18);
    chk("gate_rst_relock_done", done_o, 1);
    chk("gate_rst_relock_refdiv", refdiv_o, 1);
    chk("gate_rst_relock_fbdiv", fbdiv_o, 8);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_cfg_ctrl.md
# pll_cfg_ctrl

Sequencer that sits directly upstream of the `pll` and drives its `refdiv_i`/`fbdiv_i`. It accepts divider reconfiguration requests over a valid/ready handshake and gates the downstream clock off while the dividers change. It then waits for a qualified lock and re-enables the clock. Lock is debounced, a timeout is enforced, and loss of lock is reported. The block runs on the reference clock, which is the clock that also feeds the `pll` `clk_ref_i`.

## Interface
- `REF_DIV_WIDTH`, default 4: width of `refdiv_o`.
- `FB_DIV_WIDTH`, default 8: width of `fbdiv_o`.
- `RST_REFDIV`, default 1: `refdiv_o` value after reset.
- `RST_FBDIV`, default 8: `fbdiv_o` value after reset.
- `GATE_CYCLES`, default 4: cycles the clock is gated before the dividers change. Must be at least 1.
- `BLANK_CYCLES`, default 8: cycles after a divider change during which lock is ignored. Must be at least 1.
- `LOCK_STABLE`, default 16: consecutive synchronized-lock cycles required to declare lock. Must be at least 1.
- `TIMEOUT`, default 4096: maximum number of `LOCK_WAIT` cycles.
- `clk_i`  in  1  reference clock.
- `arst_ni`  in  1  reset; asynchronous, active-low.
- `cfg_valid_i`  in  1  reconfiguration request.
- `cfg_refdiv_i`  in  REF_DIV_WIDTH  requested reference divider.
- `cfg_fbdiv_i`  in  FB_DIV_WIDTH  requested feedback divider.
- `cfg_ready_o`  out  1  request can be accepted.
- `pll_locked_i`  in  1  `pll` `locked_o`; asynchronous to `clk_i`.
- `refdiv_o`  out  REF_DIV_WIDTH  to `pll` `refdiv_i`.
- `fbdiv_o`  out  FB_DIV_WIDTH  to `pll` `fbdiv_i`.
- `clk_en_o`  out  1  enable for the downstream clock gate on the `pll` `clk_o`.
- `done_o`  out  1  single-cycle pulse when lock is qualified.
- `lost_lock_o`  out  1  single-cycle pulse on loss of lock while in `RUN`.
- `cfg_err_o`  out  1  single-cycle pulse when a zero divider is rejected.
- `err_o`  out  1  sticky lock-timeout flag.

## Operation
- `pll_locked_i` passes through a 2-flop synchronizer reset to 0; its output is `lk`. All state decisions use `lk`.
- FSM states: `LOCK_WAIT`, `RUN`, `GATE`, `BLANK`, `FAIL`. The reset state is `LOCK_WAIT`.
- Handshake:
  - `cfg_ready_o` = 1 in `RUN` and `FAIL` only.
  - A request is accepted on a rising edge where `cfg_valid_i & cfg_ready_o`.
  - The payload is latched into a request register at that edge.
- Zero divider: an accepted request with `cfg_refdiv_i == 0` or `cfg_fbdiv_i == 0` is consumed. `cfg_err_o` pulses, there is no state change, and the dividers are unchanged.
- `LOCK_WAIT`:
  - `clk_en_o` = 0.
  - Stable counter: +1 each cycle `lk` = 1, cleared when `lk` = 0.
  - Timeout counter: +1 each cycle.
  - Both counters clear on entry to the state.
  - Stable count reaches `LOCK_STABLE`: go to `RUN` and pulse `done_o`.
  - Otherwise, timeout count reaches `TIMEOUT`: go to `FAIL` and set `err_o`.
  - If both conditions occur on the same edge, lock wins.
- `RUN`:
  - `clk_en_o` = 1.
  - `lk` = 0: go to `LOCK_WAIT` and pulse `lost_lock_o`.
  - Valid request accepted: go to `GATE`.
  - Both in the same cycle: go to `GATE` and `lost_lock_o` still pulses.
- `GATE`:
  - `clk_en_o` = 0.
  - After `GATE_CYCLES` cycles, load `refdiv_o`/`fbdiv_o` from the request register and go to `BLANK`.
- `BLANK`:
  - `clk_en_o` = 0 and `lk` is ignored.
  - After `BLANK_CYCLES` cycles, go to `LOCK_WAIT`.
- `FAIL`:
  - `clk_en_o` = 0 and `err_o` = 1.
  - A valid request is accepted: go to `GATE`, and `err_o` clears on the same edge.
  - `lk` alone never leaves `FAIL`.
- Counter widths are `$clog2(max parameter + 1)`; counters saturate and never wrap.

## Timing
- Reset values:
  - `refdiv_o` = `RST_REFDIV`, `fbdiv_o` = `RST_FBDIV`.
  - `clk_en_o`, `cfg_ready_o`, `done_o`, `lost_lock_o`, `cfg_err_o`, `err_o` = 0.
  - Synchronizer = 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs.
- For a request accepted at edge E0:
  - `clk_en_o` is low after E0.
  - Dividers change at E0+`GATE_CYCLES`.
  - `LOCK_WAIT` is entered at E0+`GATE_CYCLES`+`BLANK_CYCLES`.
- `pll_locked_i` rising to `RUN`: at least 2 synchronizer cycles plus `LOCK_STABLE` cycles. `done_o` and `clk_en_o` rise on the same edge.
- `pll_locked_i` falling in `RUN`: `clk_en_o` is low at most 3 edges later (2 synchronizer + 1 state).
- Reset asserted mid-operation: everything returns immediately to reset values and the pending request is discarded.

## Test plan
- Reset, hold `pll_locked_i` = 1 → `done_o` pulses and `clk_en_o` = 1 exactly 18 edges after release; `refdiv_o` = 1, `fbdiv_o` = 8.
- In `RUN`, request refdiv 2 / fbdiv 20 → `clk_en_o` low next cycle, dividers 2/20 at E0+4, lock ignored until E0+12, `RUN` after 16 stable cycles.
- Hold `pll_locked_i` = 0 → `err_o` = 1 after 4096 `LOCK_WAIT` cycles and `cfg_ready_o` = 1; next valid request clears `err_o` and enters `GATE`.
- In `RUN`, drop `pll_locked_i` for 1 cycle → `lost_lock_o` pulses, `clk_en_o` = 0, lock requalified over 16 cycles; a 5-cycle high/low glitch train never reaches `RUN`.
- Request with fbdiv 0 → `cfg_err_o` pulses, `fbdiv_o` unchanged, state remains `RUN`.
- Assert `arst_ni` during `GATE` → outputs return to reset values and dividers 1/8 are restored.
